// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the ID-stage hazard controller FSM encoding.
// decodeIns pulls out the fields and instruction classes that hazard detection needs.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MD_WAIT = 2'd2
    } hazState_t;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic       isMD;
        logic       isHiLo;
    } idDecode_t;

    function automatic idDecode_t decodeIns(input logic [31:0] ins);
        idDecode_t  d;
        logic [5:0] op;
        logic [5:0] funct;
        op       = ins[31:26];
        funct    = ins[5:0];
        d.rs     = ins[25:21];
        d.rt     = ins[20:16];
        d.usesRt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
        d.isMD   = (op == OP_RTYPE) && ((funct == FN_MULT) || (funct == FN_MULTU) ||
                                        (funct == FN_DIV)  || (funct == FN_DIVU));
        d.isHiLo = (op == OP_RTYPE) && ((funct == FN_MFHI) || (funct == FN_MFLO));
        return d;
    endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the ID hazard controller (slave).
interface id_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import mips_pkg::*;

    // Enables are level-sensitive and apply to the clock edge that closes the current cycle:
    // oPCWrite/oIFIDWrite low hold that register, oIFIDFlush/oIDEXBubble high insert a NOP there.
    logic [31:0]      iins;
    logic             iEX_MemRead;
    logic [4:0]       iEX_rt;
    logic             iMEM_BranchTkn;
    logic             iMD_busy;
    logic             iMD_done;
    logic             oPCWrite;
    logic             oIFIDWrite;
    logic             oIFIDFlush;
    logic             oIDEXBubble;
    logic             oMD_start;
    logic             oMD_error;
    logic [CNT_W-1:0] oStallCnt;
    logic [CNT_W-1:0] oFlushCnt;
    hazState_t        dbgState;

    modport master (
        output iins, iEX_MemRead, iEX_rt, iMEM_BranchTkn, iMD_busy, iMD_done,
        input  oPCWrite, oIFIDWrite, oIFIDFlush, oIDEXBubble, oMD_start, oMD_error,
        input  oStallCnt, oFlushCnt, dbgState
    );

    modport slave (
        input  iins, iEX_MemRead, iEX_rt, iMEM_BranchTkn, iMD_busy, iMD_done,
        output oPCWrite, oIFIDWrite, oIFIDFlush, oIDEXBubble, oMD_start, oMD_error,
        output oStallCnt, oFlushCnt, dbgState
    );

endinterface

// File: rtl/hazard_sat_counter.sv
// Saturating event counter: counts cycles with inc high and sticks at all-ones.
module hazard_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard sequencer: load-use stalls, taken-branch flushes and mult/div issue/wait,
// with same-cycle control outputs and saturating stall/flush performance counters.
module id_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MD_TIMEOUT   = 64,
    parameter int CNT_W        = 16
) (
    input logic             clk,
    input logic             rst,
    id_hazard_ctrl_if.slave hif
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [FW-1:0] FLUSH_RELOAD = FW'(FLUSH_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_LAST   = TW'(MD_TIMEOUT - 1);

    hazState_t     state;
    hazState_t     stateNext;
    logic [FW-1:0] flushRem;
    logic [FW-1:0] flushRemNext;
    logic [TW-1:0] mdTimer;
    logic [TW-1:0] mdTimerNext;
    logic          mdErr;

    idDecode_t dec;
    logic      loadUse;
    logic      flushActive;
    logic      inWait;
    logic      mdTimeout;
    logic      mdRelease;
    logic      mdStall;
    logic      mdIssue;
    logic      stall;
    logic      pcWrite;
    logic      ifidWrite;
    logic      ifidFlush;
    logic      idexBubble;
    logic      mdStart;

    always_comb begin
        dec         = decodeIns(hif.iins);
        loadUse     = hif.iEX_MemRead && (hif.iEX_rt != 5'd0) &&
                      ((hif.iEX_rt == dec.rs) || (dec.usesRt && (hif.iEX_rt == dec.rt)));
        flushActive = hif.iMEM_BranchTkn || (flushRem != '0);
        inWait      = (state == MD_WAIT);
        mdTimeout   = inWait && !hif.iMD_done && (mdTimer == TIMER_LAST);
        mdRelease   = hif.iMD_done || mdTimeout;

        // In MD_WAIT a done pulse frees the unit, so an isMD in ID may issue straight away.
        if (inWait) begin
            mdStall = (dec.isMD && hif.iMD_done && hif.iMD_busy) ||
                      ((dec.isMD || dec.isHiLo) && !mdRelease);
            mdIssue = dec.isMD && hif.iMD_done && !hif.iMD_busy;
        end else begin
            mdStall = dec.isMD && hif.iMD_busy;
            mdIssue = dec.isMD && !hif.iMD_busy;
        end

        stall = !flushActive && (loadUse || mdStall);

        if (rst) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
            mdStart    = 1'b0;
        end else begin
            pcWrite    = !stall;
            ifidWrite  = !stall;
            ifidFlush  = flushActive;
            idexBubble = flushActive || stall;
            mdStart    = !flushActive && !loadUse && mdIssue;
        end

        if (hif.iMEM_BranchTkn) begin
            flushRemNext = FLUSH_RELOAD;
        end else if (flushRem != '0) begin
            flushRemNext = flushRem - FW'(1);
        end else begin
            flushRemNext = flushRem;
        end

        // The flush down-counter runs independently, so a flush inside MD_WAIT keeps the state.
        if (mdStart) begin
            stateNext   = MD_WAIT;
            mdTimerNext = '0;
        end else if (inWait && !mdRelease) begin
            stateNext   = MD_WAIT;
            mdTimerNext = mdTimer + TW'(1);
        end else begin
            stateNext   = (flushRemNext != '0) ? FLUSH : RUN;
            mdTimerNext = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            flushRem <= '0;
            mdTimer  <= '0;
            mdErr    <= 1'b0;
        end else begin
            state    <= stateNext;
            flushRem <= flushRemNext;
            mdTimer  <= mdTimerNext;
            mdErr    <= mdErr || mdTimeout;
        end
    end

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!pcWrite),
        .count (hif.oStallCnt)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flushCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ifidFlush),
        .count (hif.oFlushCnt)
    );

    assign hif.oPCWrite    = pcWrite;
    assign hif.oIFIDWrite  = ifidWrite;
    assign hif.oIFIDFlush  = ifidFlush;
    assign hif.oIDEXBubble = idexBubble;
    assign hif.oMD_start   = mdStart;
    assign hif.oMD_error   = mdErr;
    assign hif.dbgState    = state;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed hazard scenarios then random traffic, all checked
// against a cycle-level reference model through an expected-output queue.
module tb_id_hazard_ctrl;
    import mips_pkg::*;

    localparam int FLUSH_CYCLES = 2;
    localparam int MD_TIMEOUT   = 8;
    localparam int CNT_W        = 5;
    localparam int EW           = 6 + 2 * CNT_W;
    localparam int CMAX         = (1 << CNT_W) - 1;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clk;
    logic rst;

    id_hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    id_hazard_ctrl #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .MD_TIMEOUT   (MD_TIMEOUT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc_no       = 0;

    // ---------------- reference model state ----------------
    int m_flush_left = 0;
    int m_md_cycles  = 0;
    int m_stall      = 0;
    int m_flush      = 0;
    bit m_md_wait    = 0;
    bit m_err        = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle of ID-stage behaviour computed from the hazard rules; returns this cycle's outputs.
    task automatic model_step(input bit r, input logic [31:0] ins, input bit mem_rd,
                              input logic [4:0] ex_rt, input bit br_tkn, input bit busy,
                              input bit done, output logic [EW-1:0] e);
        int op, rs, rt, fn;
        bit uses_rt, is_md, is_hilo, load_use, flushing, want_stall, want_start, timeout;
        bit pcw, ifw, fl, bub, st;
        logic [31:0] sc, fc;
        sc = m_stall;
        fc = m_flush;
        if (r) begin
            e = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, m_err, sc[CNT_W-1:0], fc[CNT_W-1:0]};
            m_flush_left = 0; m_md_wait = 0; m_md_cycles = 0;
            m_err = 0; m_stall = 0; m_flush = 0;
            return;
        end
        op = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]); fn = int'(ins[5:0]);
        uses_rt  = (op == 0) || (op == 'h2B) || (op == 'h04);
        is_md    = (op == 0) && (fn >= 'h18) && (fn <= 'h1B);
        is_hilo  = (op == 0) && ((fn == 'h10) || (fn == 'h12));
        load_use = mem_rd && (ex_rt != 0) && ((int'(ex_rt) == rs) || (uses_rt && int'(ex_rt) == rt));
        flushing = br_tkn || (m_flush_left > 0);
        want_stall = 0; want_start = 0; timeout = 0;
        if (!m_md_wait || done) begin
            if (is_md) begin
                if (busy) want_stall = 1; else want_start = 1;
            end
        end else if (m_md_cycles + 1 == MD_TIMEOUT) begin
            timeout = 1;
        end else if (is_md || is_hilo) begin
            want_stall = 1;
        end
        pcw = 1; ifw = 1; fl = 0; bub = 0; st = 0;
        if (flushing) begin
            fl = 1; bub = 1;
        end else if (load_use || want_stall) begin
            pcw = 0; ifw = 0; bub = 1;
        end else if (want_start) begin
            st = 1;
        end
        e = {pcw, ifw, fl, bub, st, m_err, sc[CNT_W-1:0], fc[CNT_W-1:0]};
        if (timeout) m_err = 1;
        if (st) begin
            m_md_wait = 1; m_md_cycles = 0;
        end else if (m_md_wait && (done || timeout)) begin
            m_md_wait = 0;
        end else if (m_md_wait) begin
            m_md_cycles++;
        end
        if (br_tkn) m_flush_left = FLUSH_CYCLES - 1;
        else if (m_flush_left > 0) m_flush_left--;
        if (!pcw && m_stall < CMAX) m_stall++;
        if (fl && m_flush < CMAX) m_flush++;
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit r, input logic [31:0] ins, input bit mem_rd,
                         input logic [4:0] ex_rt, input bit br_tkn, input bit busy, input bit done);
        logic [EW-1:0] e;
        @(posedge clk);
        #1;
        rst                = r;
        hif.iins           = ins;
        hif.iEX_MemRead    = mem_rd;
        hif.iEX_rt         = ex_rt;
        hif.iMEM_BranchTkn = br_tkn;
        hif.iMD_busy       = busy;
        hif.iMD_done       = done;
        model_step(r, ins, mem_rd, ex_rt, br_tkn, busy, done, e);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        cycle(1, NOP, 0, 5'd0, 0, 0, 0);
        cycle(1, NOP, 0, 5'd0, 0, 0, 0);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt);
        return {op, rs, rt, 16'h0010};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [4:0] a, b, c;
        logic [5:0] fn;
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        c = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 7))
            0: return rtype(a, b, c, 6'h20);
            1: return itype(6'h23, a, b);
            2: return itype(6'h2B, a, b);
            3: return itype(6'h04, a, b);
            4: begin
                fn = 6'h18 + 6'($urandom_range(0, 3));
                return rtype(a, b, 5'd0, fn);
            end
            5: return rtype(5'd0, 5'd0, c, ($urandom_range(0, 1) != 0) ? 6'h10 : 6'h12);
            6: return itype(6'h08, a, b);
            default: return NOP;
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] act;
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {hif.oPCWrite, hif.oIFIDWrite, hif.oIFIDFlush, hif.oIDEXBubble,
                   hif.oMD_start, hif.oMD_error, hif.oStallCnt, hif.oFlushCnt};
            check($sformatf("outputs cycle %0d", cyc_no), 32'(act), 32'(e));
            cyc_no++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] add_ins, mult_ins, mflo_ins;
        rst = 1'b1;
        hif.iins = NOP; hif.iEX_MemRead = 0; hif.iEX_rt = 0;
        hif.iMEM_BranchTkn = 0; hif.iMD_busy = 0; hif.iMD_done = 0;
        add_ins  = rtype(5'd2, 5'd4, 5'd3, 6'h20);
        mult_ins = rtype(5'd1, 5'd2, 5'd0, 6'h18);
        mflo_ins = rtype(5'd0, 5'd0, 5'd3, 6'h12);

        // load-use on rs
        do_reset();
        cycle(0, add_ins, 1, 5'd2, 0, 0, 0);
        cycle(0, add_ins, 0, 5'd0, 0, 0, 0);
        check("t1 stall_cnt", 32'(hif.oStallCnt), 1);
        check("t1 state_run", 32'(hif.dbgState), 32'(RUN));

        // lw $0 and lw whose rt is not a source: no stall
        cycle(0, rtype(5'd0, 5'd0, 5'd3, 6'h20), 1, 5'd0, 0, 0, 0);
        cycle(0, itype(6'h23, 5'd1, 5'd5), 1, 5'd5, 0, 0, 0);
        cycle(0, NOP, 0, 5'd0, 0, 0, 0);
        check("t2 stall_cnt", 32'(hif.oStallCnt), 1);

        // taken branch with coincident load-use, two flush cycles
        do_reset();
        cycle(0, add_ins, 1, 5'd2, 1, 0, 0);
        cycle(0, add_ins, 1, 5'd2, 0, 0, 0);
        cycle(0, NOP, 0, 5'd0, 0, 0, 0);
        check("t3 flush_cnt", 32'(hif.oFlushCnt), 2);
        check("t3 stall_cnt", 32'(hif.oStallCnt), 0);

        // mult issue, mflo waits 5 cycles, advances with done
        do_reset();
        cycle(0, mult_ins, 0, 5'd0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, mflo_ins, 0, 5'd0, 0, 1, 0);
        cycle(0, mflo_ins, 0, 5'd0, 0, 0, 1);
        cycle(0, NOP, 0, 5'd0, 0, 0, 0);
        check("t4 stall_cnt", 32'(hif.oStallCnt), 5);

        // mult/div timeout
        do_reset();
        cycle(0, mult_ins, 0, 5'd0, 0, 0, 0);
        for (int i = 0; i < MD_TIMEOUT; i++) cycle(0, mflo_ins, 0, 5'd0, 0, 1, 0);
        cycle(0, mflo_ins, 0, 5'd0, 0, 1, 0);
        check("t5 md_error", 32'(hif.oMD_error), 1);
        check("t5 stall_cnt", 32'(hif.oStallCnt), MD_TIMEOUT - 1);

        // reset inside MD_WAIT, then inside FLUSH
        cycle(0, mult_ins, 0, 5'd0, 0, 0, 0);
        cycle(0, mflo_ins, 0, 5'd0, 0, 1, 0);
        cycle(1, mflo_ins, 0, 5'd0, 0, 1, 0);
        cycle(0, mflo_ins, 0, 5'd0, 0, 1, 0);
        check("t6 md_error_cleared", 32'(hif.oMD_error), 0);
        cycle(0, NOP, 0, 5'd0, 1, 0, 0);
        cycle(1, NOP, 0, 5'd0, 0, 0, 0);
        cycle(0, NOP, 0, 5'd0, 0, 0, 0);
        check("t6 stall_cnt", 32'(hif.oStallCnt), 0);
        check("t6 flush_cnt", 32'(hif.oFlushCnt), 0);
        check("t6 state_run", 32'(hif.dbgState), 32'(RUN));

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 99) == 0), rand_ins(), ($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
        end

        @(negedge clk);
        #1;
        check("exp_q drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
